// File: rtl/fc2_param_loader_pkg.sv
// ---------------------------------------------------------------------------
// fc2_param_loader_pkg
// Shared FC2 definitions for the parameter loader: loader state encoding,
// default layer geometry, the memory/stream word sizes and a helper that
// turns a count range into a counter width.
// No ports (package).
// ---------------------------------------------------------------------------
package fc2_param_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_B = 2'd2
  } load_state_t;

  localparam int FC2_DATA_WIDTH   = 32;
  localparam int FC2_ADDRESS_BITS = 15;
  localparam int FC2_IFM_DEPTH    = 84;
  localparam int FC2_NUMBER_OF_WM = 10;

  // A counter over 0..n-1 needs $clog2(n) bits; n==1 still needs one bit
  // so that the signal exists.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FC2_WORD_CNT_BITS = cnt_width(FC2_IFM_DEPTH);
  localparam int FC2_WM_IDX_BITS   = cnt_width(FC2_NUMBER_OF_WM);

endpackage

// File: rtl/fc2_param_loader_if.sv
// ---------------------------------------------------------------------------
// fc2_param_loader_if
// Valid/ready word stream from the RISC-V/DMA side into the FC2 loader.
//   in_valid : producer has a word on in_data
//   in_data  : stream word
//   in_ready : loader accepts the word this cycle
// master = word producer, slave = loader.
// ---------------------------------------------------------------------------
interface fc2_param_loader_if
  import fc2_param_loader_pkg::*;
#(
  parameter int DATA_WIDTH = FC2_DATA_WIDTH
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/fc2_param_loader.sv
// ---------------------------------------------------------------------------
// fc2_param_loader
// Configuration sequencer for the FC2 layer. Streams IFM_DEPTH weights into
// each of the NUMBER_OF_WM weight memories in turn, then NUMBER_OF_WM biases
// into the bias memory, and holds back the layer start until a complete
// parameter set is in place.
//
// Ports:
//   clk             : clock, rising edge
//   reset           : asynchronous, active-low reset
//   cfg_start       : pulse, begins a full parameter load (ignored while busy)
//   cfg_abort       : synchronous abort of a load in progress
//   stream          : valid/ready word stream (slave side)
//   riscv_data      : registered write data to the FC2 memories
//   riscv_address   : registered write address
//   wm_enable_write : one-hot weight-memory write strobe
//   bm_enable_write : bias-memory write strobe
//   busy            : load in progress
//   cfg_done        : one-cycle pulse when the load completes
//   params_valid    : memories hold a complete parameter set
//   start_in        : start pulse from the previous layer
//   start_out       : gated start pulse forwarded to FC2
// ---------------------------------------------------------------------------
module fc2_param_loader
  import fc2_param_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = FC2_DATA_WIDTH,
  parameter int ADDRESS_BITS = FC2_ADDRESS_BITS,
  parameter int IFM_DEPTH    = FC2_IFM_DEPTH,
  parameter int NUMBER_OF_WM = FC2_NUMBER_OF_WM
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_start,
  input  logic                    cfg_abort,
  fc2_param_loader_if.slave       stream,
  output logic [DATA_WIDTH-1:0]   riscv_data,
  output logic [ADDRESS_BITS-1:0] riscv_address,
  output logic [NUMBER_OF_WM-1:0] wm_enable_write,
  output logic                    bm_enable_write,
  output logic                    busy,
  output logic                    cfg_done,
  output logic                    params_valid,
  input  logic                    start_in,
  output logic                    start_out
);

  localparam int WORD_CNT_BITS = cnt_width(IFM_DEPTH);
  localparam int WM_IDX_BITS   = cnt_width(NUMBER_OF_WM);

  localparam logic [WORD_CNT_BITS-1:0] LAST_WORD = WORD_CNT_BITS'(IFM_DEPTH - 1);
  localparam logic [WM_IDX_BITS-1:0]   LAST_WM   = WM_IDX_BITS'(NUMBER_OF_WM - 1);
  localparam logic [NUMBER_OF_WM-1:0]  WM_ONE    = NUMBER_OF_WM'(1);

  load_state_t state_q, state_d;

  logic [WORD_CNT_BITS-1:0] word_cnt;
  logic [WM_IDX_BITS-1:0]   wm_idx;
  logic [WM_IDX_BITS-1:0]   bias_cnt;
  logic                     start_pending;

  logic                     start_fire;
  logic                     accept;
  logic                     word_last;
  logic                     wm_last;
  logic                     bias_last;
  logic                     idle;

  logic [NUMBER_OF_WM-1:0]  wm_we_d;
  logic                     bm_we_d;
  logic [ADDRESS_BITS-1:0]  addr_d;
  logic                     done_d;
  logic                     start_out_d;
  logic                     pending_d;

  assign idle       = (state_q == IDLE);
  assign busy       = !idle;
  // Abort takes priority over a word offered in the same cycle, so ready drops.
  assign stream.in_ready = busy && !cfg_abort;
  assign accept     = stream.in_valid && stream.in_ready;
  assign start_fire = idle && cfg_start && !cfg_abort;
  assign word_last  = (word_cnt == LAST_WORD);
  assign wm_last    = (wm_idx == LAST_WM);
  assign bias_last  = (bias_cnt == LAST_WM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the values the write port will present one cycle after
  // an accept; addresses hold their last value when nothing is written.
  always_comb begin
    state_d = state_q;
    wm_we_d = '0;
    bm_we_d = 1'b0;
    addr_d  = riscv_address;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_fire) state_d = LOAD_W;
      end
      LOAD_W: begin
        if (accept) begin
          wm_we_d = WM_ONE << wm_idx;
          addr_d  = ADDRESS_BITS'(word_cnt);
        end
        if (cfg_abort) state_d = IDLE;
        else if (accept && word_last && wm_last) state_d = LOAD_B;
      end
      LOAD_B: begin
        if (accept) begin
          bm_we_d = 1'b1;
          addr_d  = ADDRESS_BITS'(bias_cnt);
        end
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (accept && bias_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word/memory/bias position. Cleared on a new load and on abort so the
  // next load always begins at weight memory 0, address 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt <= '0;
      wm_idx   <= '0;
      bias_cnt <= '0;
    end else if (start_fire || (busy && cfg_abort)) begin
      word_cnt <= '0;
      wm_idx   <= '0;
      bias_cnt <= '0;
    end else if (accept) begin
      if (state_q == LOAD_W) begin
        if (word_last) begin
          word_cnt <= '0;
          wm_idx   <= wm_last ? '0 : wm_idx + 1'b1;
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end else if (state_q == LOAD_B) begin
        bias_cnt <= bias_last ? '0 : bias_cnt + 1'b1;
      end
    end
  end

  // Registered write port and completion status. params_valid rises in the
  // same cycle as the final bias write and cfg_done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      riscv_data      <= '0;
      riscv_address   <= '0;
      wm_enable_write <= '0;
      bm_enable_write <= 1'b0;
      cfg_done        <= 1'b0;
      params_valid    <= 1'b0;
    end else begin
      if (accept) riscv_data <= stream.in_data;
      riscv_address   <= addr_d;
      wm_enable_write <= wm_we_d;
      bm_enable_write <= bm_we_d;
      cfg_done        <= done_d;
      if (start_fire) params_valid <= 1'b0;
      else if (done_d) params_valid <= 1'b1;
    end
  end

  // Start gate: pass start_in straight through when parameters are ready,
  // otherwise remember it (repeats collapse) and release one pulse once
  // params_valid is up. A new load or an abort drops a remembered start.
  always_comb begin
    start_out_d = (start_in && params_valid && idle) ||
                  (start_pending && params_valid);
    pending_d   = start_pending;
    if (cfg_abort || start_fire) begin
      pending_d = 1'b0;
    end else if (start_pending && params_valid) begin
      pending_d = 1'b0;
    end else if (start_in && !(params_valid && idle)) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_out     <= 1'b0;
      start_pending <= 1'b0;
    end else begin
      start_out     <= start_out_d;
      start_pending <= pending_d;
    end
  end

endmodule

// File: tb/tb_fc2_param_loader.sv
// ---------------------------------------------------------------------------
// tb_fc2_param_loader
// Directed bench for the FC2 parameter loader. Every accepted stream word
// pushes its expected memory write onto a queue; a negedge monitor pops and
// compares each strobed write and tracks cfg_done / start_out pulses.
// ---------------------------------------------------------------------------
module tb_fc2_param_loader;
  import fc2_param_loader_pkg::*;

  localparam int DW    = 32;
  localparam int AB    = 15;
  localparam int DEPTH = 84;
  localparam int NWM   = 10;
  localparam int NW    = NWM * DEPTH;
  localparam int TOTAL = NWM * (DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_abort = 1'b0;
  logic          start_in = 1'b0;
  logic [DW-1:0] riscv_data;
  logic [AB-1:0] riscv_address;
  logic [NWM-1:0] wm_enable_write;
  logic          bm_enable_write;
  logic          busy;
  logic          cfg_done;
  logic          params_valid;
  logic          start_out;

  fc2_param_loader_if #(.DATA_WIDTH(DW)) stream ();

  fc2_param_loader #(
    .DATA_WIDTH  (DW),
    .ADDRESS_BITS(AB),
    .IFM_DEPTH   (DEPTH),
    .NUMBER_OF_WM(NWM)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_abort      (cfg_abort),
    .stream         (stream),
    .riscv_data     (riscv_data),
    .riscv_address  (riscv_address),
    .wm_enable_write(wm_enable_write),
    .bm_enable_write(bm_enable_write),
    .busy           (busy),
    .cfg_done       (cfg_done),
    .params_valid   (params_valid),
    .start_in       (start_in),
    .start_out      (start_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NWM-1:0] wm;
    logic           bm;
    logic [AB-1:0]  addr;
    logic [DW-1:0]  data;
    logic           last;
  } wr_t;

  wr_t sb[$];

  int test_cnt = 0;
  int fail_cnt = 0;
  bit exp_loading = 1'b0;
  int exp_count = 0;
  int cyc = 0;
  int done_pulses = 0;
  int start_pulses = 0;
  int pv_rise_cyc = -1;
  int start_cyc = -1;
  logic pv_prev = 1'b0;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream word c (0-based) lands in weight memory c/DEPTH at c%DEPTH,
  // then the last NWM words go to bias addresses 0..NWM-1.
  function automatic wr_t expected_write(input int c, input logic [DW-1:0] d);
    wr_t w;
    w.data = d;
    w.last = (c == TOTAL - 1);
    if (c < NW) begin
      w.wm   = NWM'(1) << (c / DEPTH);
      w.bm   = 1'b0;
      w.addr = AB'(c % DEPTH);
    end else begin
      w.wm   = '0;
      w.bm   = 1'b1;
      w.addr = AB'(c - NW);
    end
    return w;
  endfunction

  // One clock of stimulus: drive at negedge, check ready/busy, then update
  // the reference model at the sampling edge.
  task automatic apply_stimulus(input logic v, input logic [DW-1:0] d, input logic st,
                                input logic ab, input logic si);
    bit was_loading;
    @(negedge clk);
    stream.in_valid = v;
    stream.in_data  = d;
    cfg_start       = st;
    cfg_abort       = ab;
    start_in        = si;
    #1;
    check_output("in_ready", stream.in_ready, exp_loading && !ab);
    check_output("busy", busy, exp_loading);
    @(posedge clk);
    was_loading = exp_loading;
    if (was_loading && ab) begin
      exp_loading = 1'b0;
    end else if (was_loading && v) begin
      sb.push_back(expected_write(exp_count, d));
      exp_count++;
      if (exp_count == TOTAL) exp_loading = 1'b0;
    end else if (!was_loading && st && !ab) begin
      exp_loading = 1'b1;
      exp_count   = 0;
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check_output("rst_in_ready", stream.in_ready, 0);
    check_output("rst_riscv_data", riscv_data, 0);
    check_output("rst_riscv_address", riscv_address, 0);
    check_output("rst_wm_enable_write", wm_enable_write, 0);
    check_output("rst_bm_enable_write", bm_enable_write, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_cfg_done", cfg_done, 0);
    check_output("rst_params_valid", params_valid, 0);
    check_output("rst_start_out", start_out, 0);
  endtask

  // Start a load and feed words 1,2,3,... until stop_after words are accepted.
  // start_in is pulsed alongside word index start_at (-1 for never).
  task automatic full_load(input bit gaps, input int start_at, input int stop_after);
    int   sent;
    logic v;
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    check_output("params_valid_cleared", params_valid, 0);
    sent = 0;
    for (int i = 0; i < 8 * TOTAL && sent < stop_after; i++) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      apply_stimulus(v, v ? DW'(sent + 1) : DW'(32'hBAD0_0000 + i), 1'b0, 1'b0,
                     v && (sent == start_at));
      if (v) sent++;
    end
    check_output("load_word_budget", sent, stop_after);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every strobed cycle must match the oldest expected write.
  always @(negedge clk) begin
    wr_t w;
    if (reset) begin
      if (wm_enable_write !== '0 || bm_enable_write !== 1'b0) begin
        if (sb.size() == 0) begin
          check_output("unexpected_write", {wm_enable_write, bm_enable_write}, 0);
        end else begin
          w = sb.pop_front();
          check_output("wr_wm", wm_enable_write, w.wm);
          check_output("wr_bm", bm_enable_write, w.bm);
          check_output("wr_addr", riscv_address, w.addr);
          check_output("wr_data", riscv_data, w.data);
          check_output("wr_cfg_done", cfg_done, w.last);
          check_output("wr_params_valid", params_valid, w.last);
        end
      end else if (cfg_done !== 1'b0) begin
        check_output("cfg_done_without_write", cfg_done, 0);
      end
      if (cfg_done === 1'b1) done_pulses++;
      if (params_valid === 1'b1 && pv_prev !== 1'b1) pv_rise_cyc = cyc;
      if (start_out === 1'b1) begin
        start_pulses++;
        start_cyc = cyc;
      end
      pv_prev = params_valid;
    end else begin
      pv_prev = 1'b0;
    end
  end

  initial begin
    int sp;
    stream.in_valid = 1'b0;
    stream.in_data  = '0;

    // Reset state
    #3;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Full load, valid held high, data 1..850
    full_load(1'b0, -1, TOTAL);
    drain(3);
    check_output("t1_sb_empty", sb.size(), 0);
    check_output("t1_done_pulses", done_pulses, 1);
    check_output("t1_params_valid", params_valid, 1);
    check_output("t1_busy", busy, 0);
    check_output("t1_data_hold", riscv_data, TOTAL);
    check_output("t1_addr_hold", riscv_address, NWM - 1);

    // Same load with random valid gaps
    full_load(1'b1, -1, TOTAL);
    drain(3);
    check_output("t2_sb_empty", sb.size(), 0);
    check_output("t2_done_pulses", done_pulses, 2);
    check_output("t2_params_valid", params_valid, 1);

    // Abort after 100 words; the word offered with the abort is refused
    full_load(1'b0, -1, 100);
    apply_stimulus(1'b1, 32'h0000_ABCD, 1'b0, 1'b1, 1'b0);
    drain(3);
    check_output("t3_sb_empty", sb.size(), 0);
    check_output("t3_params_valid", params_valid, 0);
    check_output("t3_busy", busy, 0);
    check_output("t3_done_pulses", done_pulses, 2);
    check_output("t3_data_hold", riscv_data, 100);

    // Abort wins over a simultaneous start in IDLE
    apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    #1;
    check_output("t3_abort_beats_start", busy, 0);

    // Reload from wm 0 / address 0 with start_in pulsed at word 5
    sp = start_pulses;
    full_load(1'b1, 5, TOTAL);
    check_output("t4_no_start_during_load", start_pulses, sp);
    drain(4);
    check_output("t4_sb_empty", sb.size(), 0);
    check_output("t4_done_pulses", done_pulses, 3);
    check_output("t4_start_pulses", start_pulses, sp + 1);
    check_output("t4_start_after_pv", start_cyc, pv_rise_cyc + 1);

    // Direct start with params_valid, then a start held across a reload
    sp = start_pulses;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    #1;
    check_output("t5_direct_start", start_out, 1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("t5_start_one_cycle", start_out, 0);
    full_load(1'b0, 10, TOTAL);
    check_output("t5_held_during_load", start_pulses, sp + 1);
    drain(4);
    check_output("t5_sb_empty", sb.size(), 0);
    check_output("t5_start_pulses", start_pulses, sp + 2);
    check_output("t5_start_after_pv", start_cyc, pv_rise_cyc + 1);
    check_output("t5_done_pulses", done_pulses, 4);

    // Asynchronous reset in the middle of a load
    full_load(1'b0, -1, 400);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    sb.delete();
    exp_loading = 1'b0;
    exp_count   = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 32'h0000_0077, 1'b0, 1'b0, 1'b0);
    full_load(1'b0, -1, TOTAL);
    drain(3);
    check_output("t6_sb_empty", sb.size(), 0);
    check_output("t6_done_pulses", done_pulses, 5);
    check_output("t6_params_valid", params_valid, 1);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
